// File: rtl/alu_exec_ctrl.sv
// Multi-cycle execute controller feeding a combinational ALU from a 16x16 register file.
// Latency: accept at edge k, operands at k+1, result capture at k+2, write-back and done at k+3.
// Backpressure: one instruction in flight; start is only sampled in IDLE and never queued.
module alu_exec_ctrl #(
    parameter int DATA_W = 16,
    parameter int NREG   = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [15:0]       instr,
    output logic              busy,
    output logic              done,
    output logic [DATA_W-1:0] alu_a,
    output logic [DATA_W-1:0] alu_b,
    output logic [7:0]        alu_opcode,
    input  logic [DATA_W-1:0] alu_c,
    input  logic [4:0]        alu_flags,
    output logic [4:0]        psr,
    input  logic [3:0]        dbg_sel,
    output logic [DATA_W-1:0] dbg_data
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        DECODE = 2'd1,
        EXEC   = 2'd2,
        WB     = 2'd3
    } state_t;

    state_t            state;
    logic [15:0]       instr_q;
    logic [DATA_W-1:0] res_q;
    logic [4:0]        flg_q;
    logic [DATA_W-1:0] regs [NREG];

    // Instruction fields, decoded from the latched copy so they stay stable for all phases
    logic [3:0] op;
    logic [3:0] rd;
    logic [3:0] ext;
    logic [3:0] rs;
    logic [7:0] imm;
    logic       is_reg;
    logic       is_cmp;

    assign op     = instr_q[15:12];
    assign rd     = instr_q[11:8];
    assign ext    = instr_q[7:4];
    assign rs     = instr_q[3:0];
    assign imm    = instr_q[7:0];
    assign is_reg = (op == 4'b0000);
    // Compare only updates flags; it never writes a register
    assign is_cmp = is_reg ? (ext == 4'b1011) : (op == 4'b1011);

    assign dbg_data = regs[dbg_sel];

    // Control FSM with registered ALU drive, result capture and write-back
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            instr_q    <= '0;
            res_q      <= '0;
            flg_q      <= '0;
            alu_a      <= '0;
            alu_b      <= '0;
            alu_opcode <= '0;
            psr        <= '0;
            busy       <= 1'b0;
            done       <= 1'b0;
            for (int i = 0; i < NREG; i++) begin
                regs[i] <= '0;
            end
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        instr_q <= instr;
                        busy    <= 1'b1;
                        state   <= DECODE;
                    end
                end
                DECODE: begin
                    // Both operands are read here, so rd==rs sees the pre-write value
                    alu_a <= regs[rd];
                    if (is_reg) begin
                        alu_b      <= regs[rs];
                        alu_opcode <= {4'b0000, ext};
                    end else begin
                        alu_b      <= {{(DATA_W-8){imm[7]}}, imm};
                        alu_opcode <= {op, 4'b0000};
                    end
                    state <= EXEC;
                end
                EXEC: begin
                    // ALU has had a full cycle on stable operands
                    res_q <= alu_c;
                    flg_q <= alu_flags;
                    state <= WB;
                end
                WB: begin
                    if (!is_cmp) begin
                        regs[rd] <= res_q;
                    end
                    psr   <= flg_q;
                    done  <= 1'b1;
                    busy  <= 1'b0;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_alu_exec_ctrl.sv
// Scoreboard bench for alu_exec_ctrl with a behavioural ALU closing the loop.
// Stimulus pushes the expected register value and flags; a monitor pops on each done pulse.
module tb_alu_exec_ctrl;

    logic        clk;
    logic        rst_n;
    logic        start;
    logic [15:0] instr;
    logic        busy;
    logic        done;
    logic [15:0] alu_a;
    logic [15:0] alu_b;
    logic [7:0]  alu_opcode;
    logic [15:0] alu_c;
    logic [4:0]  alu_flags;
    logic [4:0]  psr;
    logic [3:0]  dbg_sel;
    logic [15:0] dbg_data;

    int n_cmp  = 0;
    int n_fail = 0;
    int n_done = 0;

    typedef struct {
        logic [3:0]  rd;
        logic [15:0] val;
        logic [4:0]  flags;
    } exp_t;

    exp_t sb[$];

    alu_exec_ctrl #(.DATA_W(16), .NREG(16)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start),
        .instr      (instr),
        .busy       (busy),
        .done       (done),
        .alu_a      (alu_a),
        .alu_b      (alu_b),
        .alu_opcode (alu_opcode),
        .alu_c      (alu_c),
        .alu_flags  (alu_flags),
        .psr        (psr),
        .dbg_sel    (dbg_sel),
        .dbg_data   (dbg_data)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Behavioural ALU: flags = {0, V, C, N, Z}
    always_comb begin
        logic [16:0] s;
        logic        v;
        s = '0;
        v = 1'b0;
        case (alu_opcode)
            8'h05, 8'h50: begin
                s = {1'b0, alu_a} + {1'b0, alu_b};
                v = (alu_a[15] == alu_b[15]) && (s[15] != alu_a[15]);
            end
            8'h0B, 8'hB0: begin
                s = {1'b0, alu_a} + {1'b0, ~alu_b} + 17'd1;
                v = (alu_a[15] != alu_b[15]) && (s[15] != alu_a[15]);
            end
            default: s = {1'b0, alu_a ^ alu_b};
        endcase
        alu_c     = s[15:0];
        alu_flags = {1'b0, v, s[16], s[15], (s[15:0] == 16'h0000)};
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_cmp++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", name, act, req);
        end
    endtask

    // Monitor: every done pulse must match the oldest expected write-back
    initial begin
        dbg_sel = 4'd0;
        forever begin
            @(negedge clk);
            if (done === 1'b1) begin
                n_done++;
                if (sb.size() == 0) begin
                    n_cmp++;
                    n_fail++;
                    $display("FAIL unexpected_done: got done=1, expected no completion");
                end else begin
                    exp_t e;
                    e = sb.pop_front();
                    dbg_sel = e.rd;
                    #1;
                    check("wb_reg", {16'h0, dbg_data}, {16'h0, e.val});
                    check("wb_psr", {27'h0, psr}, {27'h0, e.flags});
                end
            end
        end
    end

    // Issue one instruction, check operand drive and handshake timing
    task automatic issue(input logic [15:0] ins, input logic [15:0] ea, input logic [15:0] eb,
                         input logic [7:0] eop, input logic [3:0] erd, input logic [15:0] eval,
                         input logic [4:0] eflg);
        exp_t e;
        @(negedge clk);
        start = 1'b1;
        instr = ins;
        e.rd = erd; e.val = eval; e.flags = eflg;
        sb.push_back(e);
        @(posedge clk); #1;               // edge k
        start = 1'b0;
        check("busy_rise", {31'h0, busy}, 32'd1);
        @(posedge clk); #1;               // edge k+1
        check("alu_a", {16'h0, alu_a}, {16'h0, ea});
        check("alu_b", {16'h0, alu_b}, {16'h0, eb});
        check("alu_opcode", {24'h0, alu_opcode}, {24'h0, eop});
        @(posedge clk); #1;               // edge k+2
        check("done_early", {31'h0, done}, 32'd0);
        @(posedge clk); #1;               // edge k+3
        check("done_pulse", {31'h0, done}, 32'd1);
        check("busy_fall", {31'h0, busy}, 32'd0);
        @(posedge clk); #1;               // edge k+4
        check("done_one_cycle", {31'h0, done}, 32'd0);
    endtask

    initial begin
        rst_n = 1'b0;
        start = 1'b0;
        instr = 16'h0;
        #12;
        check("rst_busy", {31'h0, busy}, 32'd0);
        check("rst_done", {31'h0, done}, 32'd0);
        check("rst_psr", {27'h0, psr}, 32'd0);
        check("rst_opcode", {24'h0, alu_opcode}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // Abort ADDI r1,5 with reset while in EXEC
        @(negedge clk);
        start = 1'b1;
        instr = 16'h5105;
        @(posedge clk); #1;
        start = 1'b0;
        @(posedge clk); #1;
        check("pre_abort_opcode", {24'h0, alu_opcode}, 32'h50);
        rst_n = 1'b0;
        #1;
        check("abort_busy", {31'h0, busy}, 32'd0);
        check("abort_done", {31'h0, done}, 32'd0);
        check("abort_psr", {27'h0, psr}, 32'd0);
        check("abort_alu_b", {16'h0, alu_b}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (4) @(posedge clk);        // monitor flags any stray done

        // ADDI r1,5: alu_a==0 also proves the aborted write never landed
        issue(16'h5105, 16'h0000, 16'h0005, 8'h50, 4'd1, 16'h0005, 5'h00);
        // ADDI r2,-3: sign-extended immediate
        issue(16'h52FD, 16'h0000, 16'hFFFD, 8'h50, 4'd2, 16'hFFFD, 5'h02);
        // ADD r1,r2: 5 + 0xFFFD = 2 with carry out
        issue(16'h0152, 16'h0005, 16'hFFFD, 8'h05, 4'd1, 16'h0002, 5'h04);
        // CMP r1,r2: flags only, R1 keeps 2
        issue(16'h01B2, 16'h0002, 16'hFFFD, 8'h0B, 4'd1, 16'h0002, 5'h00);

        // Hold start high: accepts at posedges 1,5,9,13 -> four increments of R1
        for (int i = 0; i < 4; i++) begin
            exp_t e;
            e.rd = 4'd1; e.val = 16'(3 + i); e.flags = 5'h00;
            sb.push_back(e);
        end
        @(negedge clk);
        start = 1'b1;
        instr = 16'h5101;
        repeat (13) @(posedge clk);
        #1;
        start = 1'b0;
        repeat (6) @(posedge clk);
        #2;
        check("sb_drained", sb.size(), 32'd0);
        check("done_count", n_done, 32'd8);
        check("final_busy", {31'h0, busy}, 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/alu_exec_ctrl.md
# alu_exec_ctrl

Multi-cycle execute controller that sits directly upstream of `alu`. It decodes one 16-bit instruction, reads operands from an internal 16x16 register file, and drives the ALU's `A`, `B` and `Opcode` inputs. It then captures `C` and `Flags`, writes the result back, and updates the processor status register (PSR). A start/done handshake lets the fetch logic issue one instruction at a time.

## Interface
- `DATA_W`, 16, datapath and register width
- `NREG`, 16, register count (index width 4)
- `clk`  in  1  rising-edge clock
- `rst_n`  in  1  asynchronous active-low reset
- `start`  in  1  issue request; sampled only in IDLE
- `instr`  in  16  instruction; sampled with `start`
- `busy`  out  1  high from the cycle after acceptance until `done`
- `done`  out  1  one-cycle completion pulse
- `alu_a`  out  16  to `alu.A`
- `alu_b`  out  16  to `alu.B`
- `alu_opcode`  out  8  to `alu.Opcode`
- `alu_c`  in  16  from `alu.C`
- `alu_flags`  in  5  from `alu.Flags`
- `psr`  out  5  latched flags
- `dbg_sel`  in  4  register-file debug read index
- `dbg_data`  out  16  combinational read of `R[dbg_sel]`

## Operation

**Instruction decode**
- Fields: `op=instr[15:12]`, `rd=instr[11:8]`, `ext=instr[7:4]`, `rs=instr[3:0]`, `imm=instr[7:0]`.
- Register form (`op==4'b0000`):
  - `alu_opcode={4'b0000,ext}`
  - `alu_a=R[rd]`, `alu_b=R[rs]`
- Immediate form (`op!=0`):
  - `alu_opcode={op,4'b0000}`
  - `alu_a=R[rd]`, `alu_b` = sign-extended `imm` (e.g. 8'hFD gives 16'hFFFD)
- Compare (register `ext==4'b1011`, or immediate `op==4'b1011`):
  - PSR is updated.
  - No register write occurs.
- All other instructions write `alu_c` to `R[rd]` and update PSR.
- The ALU is purely combinational. This block does not interpret flag bits; it copies `alu_flags` to `psr` verbatim.

**State machine: IDLE -> DECODE -> EXEC -> WB -> IDLE**
- IDLE
  - `start=1`: latch `instr`, go to DECODE.
  - `start=0`: stay in IDLE.
- DECODE
  - Register `alu_a`, `alu_b` and `alu_opcode` from the register file and decode.
  - Go to EXEC.
- EXEC
  - Register `alu_c` and `alu_flags` into internal result/flag holding registers.
  - Go to WB.
- WB
  - Perform the register-file write (if enabled) and the `psr` update.
  - Assert `done` (registered).
  - Go to IDLE.
- `start` while not in IDLE is ignored; no queueing.
- `rd==rs` is legal: both operands read the pre-write value.
- Register-file writes occur only in the WB transition. There is no other write path.

**Reset** (asynchronous, any state, including mid-instruction)
- State goes to IDLE.
- All `R[i]`, `psr`, `alu_a`, `alu_b`, `alu_opcode` are cleared to 0.
- `busy=0`, `done=0`.
- No write-back occurs for the aborted instruction.

## Timing
- Let `start` be sampled high in IDLE at edge k.
- Edge k:
  - `busy` rises.
  - `instr` is latched.
- Edge k+1: `alu_a`, `alu_b`, `alu_opcode` become valid and are held stable until the next issue.
- Edge k+2: ALU result is captured. The ALU therefore has one full cycle to settle.
- Edge k+3:
  - `R[rd]` and `psr` are updated.
  - `done=1` for exactly one cycle.
  - `busy` falls in the same cycle `done` rises.
- Back-to-back operation:
  - A new `start` may be sampled at edge k+4, i.e. the cycle `done` is high.
  - Peak throughput is one instruction per 4 cycles.
- `dbg_data` reflects a write from the cycle after edge k+3.
- `psr` holds its value between instructions.

## Test plan
- Reset mid-op: issue 0x5105, assert `rst_n=0` during EXEC -> `done` never pulses; `R1=0`, `psr=0`, `busy=0`.
- ADDI: from reset, issue 0x5105 (ADDI r1,5) -> during EXEC `alu_opcode=8'h50`, `alu_a=0`, `alu_b=5`; `done` at k+3; `R1=5`.
- Negative immediate: issue 0x52FD (ADDI r2,-3) -> `alu_b=16'hFFFD`; `R2=16'hFFFD`.
- Register ADD: with `R1=5`, `R2=0xFFFD`, issue 0x0152 -> `alu_opcode=8'h05`; `R1=2`; `psr` equals the ALU flags for 5+(-3).
- Compare: issue 0x01B2 -> `R1` stays 2; `psr` updates to the ALU flags; `done` pulses.
- Handshake: hold `start=1` continuously with 0x5101 -> exactly one increment per 4 cycles; `start` pulses during `busy` are ignored; `R1` count matches accepted issues.
